// File: rtl/vc_synchronous_sram_nr1w.sv
// Multi-read, single-write synchronous SRAM with byte enables,
// a post-reset init sweep and a 1- or 2-edge read pipeline.
module vc_synchronous_sram_nr1w #(
  parameter int unsigned p_data_nbits   = 32,
  parameter int unsigned p_num_entries  = 256,
  parameter int unsigned p_num_rports   = 2,
  parameter int unsigned p_read_latency = 1,
  parameter int unsigned p_write_first  = 0,
  parameter logic [p_data_nbits-1:0] p_init_value = '0,
  localparam int unsigned c_addr_nbits  = $clog2(p_num_entries),
  localparam int unsigned c_data_nbytes = (p_data_nbits + 7) / 8
) (
  input  logic                                   clk,
  input  logic                                   reset,
  output logic                                   init_busy,
  input  logic [p_num_rports-1:0]                read_en,
  input  logic [p_num_rports*c_addr_nbits-1:0]   read_addr,
  output logic [p_num_rports-1:0]                read_val,
  output logic [p_num_rports*p_data_nbits-1:0]   read_data,
  input  logic                                   write_en,
  input  logic [c_data_nbytes-1:0]               write_byte_en,
  input  logic [c_addr_nbits-1:0]                write_addr,
  input  logic [p_data_nbits-1:0]                write_data
);

  localparam logic [0:0] STATE_INIT  = 1'b0;
  localparam logic [0:0] STATE_READY = 1'b1;

  localparam logic [c_addr_nbits-1:0] c_last =
    c_addr_nbits'(p_num_entries - 1);

  logic [0:0]              state_q;
  logic [0:0]              state_d;
  logic [c_addr_nbits-1:0] init_ctr_q;
  logic [c_addr_nbits-1:0] init_ctr_d;

  logic [p_data_nbits-1:0] mem_q [p_num_entries];

  logic                    ready;
  logic                    wr_in_range;
  logic [p_data_nbits-1:0] wr_old;
  logic [p_data_nbits-1:0] wr_merged;

  assign ready       = (state_q == STATE_READY);
  assign init_busy   = (state_q == STATE_INIT);
  assign wr_in_range = 32'(write_addr) < p_num_entries;

  // Init sweep: walk every entry once, then serve requests.
  always_comb begin
    state_d    = state_q;
    init_ctr_d = init_ctr_q;
    unique case (state_q)
      STATE_INIT: begin
        init_ctr_d = init_ctr_q + 1'b1;
        if (init_ctr_q == c_last) begin
          state_d = STATE_READY;
        end
      end
      default: begin
        state_d = STATE_READY;
      end
    endcase
  end

  // FSM and sweep counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= STATE_INIT;
      init_ctr_q <= '0;
    end else begin
      state_q    <= state_d;
      init_ctr_q <= init_ctr_d;
    end
  end

  // Byte-enable merge of the incoming write over the current entry.
  always_comb begin
    wr_old = '0;
    if (wr_in_range) begin
      wr_old = mem_q[write_addr];
    end
    wr_merged = wr_old;
    for (int b = 0; b < int'(p_data_nbits); b++) begin
      if (write_byte_en[b/8]) begin
        wr_merged[b] = write_data[b];
      end
    end
  end

  // Storage: init pattern during the sweep, merged writes when ready.
  always_ff @(posedge clk) begin
    if (state_q == STATE_INIT) begin
      mem_q[init_ctr_q] <= p_init_value;
    end else if (write_en && wr_in_range) begin
      mem_q[write_addr] <= wr_merged;
    end
  end

  for (genvar g = 0; g < int'(p_num_rports); g++) begin : g_port
    logic [c_addr_nbits-1:0] ra;
    logic [p_data_nbits-1:0] word;
    logic                    take;
    logic                    s1_val_q;
    logic [p_data_nbits-1:0] s1_data_q;

    assign ra   = read_addr[g*c_addr_nbits +: c_addr_nbits];
    assign take = ready && read_en[g];

    // Array lookup with optional write-first bypass.
    always_comb begin
      word = '0;
      if (32'(ra) < p_num_entries) begin
        word = mem_q[ra];
        if ((p_write_first != 0) && write_en
            && wr_in_range && (write_addr == ra)) begin
          word = wr_merged;
        end
      end
    end

    // First read stage; data only moves on an accepted request.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        s1_val_q  <= 1'b0;
        s1_data_q <= '0;
      end else begin
        s1_val_q <= take;
        if (take) begin
          s1_data_q <= word;
        end
      end
    end

    if (p_read_latency == 2) begin : g_lat2
      logic                    s2_val_q;
      logic [p_data_nbits-1:0] s2_data_q;

      // Second read stage, holds data between valid pulses.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          s2_val_q  <= 1'b0;
          s2_data_q <= '0;
        end else begin
          s2_val_q <= s1_val_q;
          if (s1_val_q) begin
            s2_data_q <= s1_data_q;
          end
        end
      end

      assign read_val[g] = s2_val_q;
      assign read_data[g*p_data_nbits +: p_data_nbits] = s2_data_q;
    end else begin : g_lat1
      assign read_val[g] = s1_val_q;
      assign read_data[g*p_data_nbits +: p_data_nbits] = s1_data_q;
    end
  end

endmodule

// File: tb/tb_vc_synchronous_sram_nr1w.sv
// Bench for vc_synchronous_sram_nr1w: two instances (lat1/old-data and
// lat2/new-data) driven identically and compared to a queue-based model.
module tb_vc_synchronous_sram_nr1w;

  localparam int N = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  read_en;
  logic [5:0]  read_addr;
  logic        write_en;
  logic [1:0]  wbe;
  logic [2:0]  waddr;
  logic [15:0] wdata;

  logic        busy_a, busy_b;
  logic [1:0]  val_a, val_b;
  logic [31:0] data_a, data_b;

  int checks = 0;
  int errors = 0;
  bit run = 1'b0;

  always #5 clk = ~clk;

  vc_synchronous_sram_nr1w #(
    .p_data_nbits(16), .p_num_entries(5), .p_num_rports(2),
    .p_read_latency(1), .p_write_first(0), .p_init_value(16'h0000)
  ) dut_a (
    .clk(clk), .reset(rst), .init_busy(busy_a),
    .read_en(read_en), .read_addr(read_addr),
    .read_val(val_a), .read_data(data_a),
    .write_en(write_en), .write_byte_en(wbe),
    .write_addr(waddr), .write_data(wdata)
  );

  vc_synchronous_sram_nr1w #(
    .p_data_nbits(16), .p_num_entries(5), .p_num_rports(2),
    .p_read_latency(2), .p_write_first(1), .p_init_value(16'h0000)
  ) dut_b (
    .clk(clk), .reset(rst), .init_busy(busy_b),
    .read_en(read_en), .read_addr(read_addr),
    .read_val(val_b), .read_data(data_b),
    .write_en(write_en), .write_byte_en(wbe),
    .write_addr(waddr), .write_data(wdata)
  );

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h required %h", nm, got, exp);
    end
  endtask

  function automatic logic [15:0] merge(input logic [15:0] old,
                                        input logic [1:0] be,
                                        input logic [15:0] nw);
    logic [15:0] r;
    r = old;
    if (be[0]) r[7:0]  = nw[7:0];
    if (be[1]) r[15:8] = nw[15:8];
    return r;
  endfunction

  // Model: instance d has latency d+1 and write-first == d.
  typedef struct {
    int          d;
    int          p;
    int          due;
    logic [15:0] data;
  } rd_t;

  rd_t         pend[$];
  rd_t         keep[$];
  logic [15:0] mem_m [N];
  bit          init_m = 1'b1;
  int          ictr = 0;
  int          ecnt = 0;
  bit          val_m  [2][2];
  logic [15:0] hold_m [2][2];

  initial begin
    foreach (val_m[d, p]) begin
      val_m[d][p]  = 1'b0;
      hold_m[d][p] = 16'h0;
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      init_m = 1'b1;
      ictr   = 0;
      pend.delete();
      foreach (val_m[d, p]) begin
        val_m[d][p]  = 1'b0;
        hold_m[d][p] = 16'h0;
      end
    end else begin
      ecnt++;
      foreach (val_m[d, p]) val_m[d][p] = 1'b0;
      if (init_m) begin
        mem_m[ictr] = 16'h0;
        ictr++;
        if (ictr == N) init_m = 1'b0;
      end else begin
        for (int d = 0; d < 2; d++) begin
          for (int p = 0; p < 2; p++) begin
            if (read_en[p]) begin
              int a;
              logic [15:0] v;
              a = int'(read_addr[p*3 +: 3]);
              if (a >= N) v = 16'h0;
              else if (d == 1 && write_en && int'(waddr) == a)
                v = merge(mem_m[a], wbe, wdata);
              else v = mem_m[a];
              pend.push_back('{d, p, ecnt + d, v});
            end
          end
        end
        if (write_en && int'(waddr) < N)
          mem_m[waddr] = merge(mem_m[waddr], wbe, wdata);
      end
      keep.delete();
      foreach (pend[i]) begin
        if (pend[i].due == ecnt) begin
          val_m[pend[i].d][pend[i].p]  = 1'b1;
          hold_m[pend[i].d][pend[i].p] = pend[i].data;
        end else begin
          keep.push_back(pend[i]);
        end
      end
      pend = keep;
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (run) begin
      chk("busy_a", {31'b0, busy_a}, {31'b0, rst | init_m});
      chk("busy_b", {31'b0, busy_b}, {31'b0, rst | init_m});
      for (int p = 0; p < 2; p++) begin
        chk($sformatf("val_a%0d", p), {31'b0, val_a[p]},
            {31'b0, rst ? 1'b0 : val_m[0][p]});
        chk($sformatf("val_b%0d", p), {31'b0, val_b[p]},
            {31'b0, rst ? 1'b0 : val_m[1][p]});
        chk($sformatf("data_a%0d", p), {16'b0, data_a[p*16 +: 16]},
            {16'b0, rst ? 16'h0 : hold_m[0][p]});
        chk($sformatf("data_b%0d", p), {16'b0, data_b[p*16 +: 16]},
            {16'b0, rst ? 16'h0 : hold_m[1][p]});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [1:0] re, input int a0, input int a1,
                    input logic we, input logic [1:0] be,
                    input int wa, input logic [15:0] wd);
    read_en   = re;
    read_addr = {a1[2:0], a0[2:0]};
    write_en  = we;
    wbe       = be;
    waddr     = wa[2:0];
    wdata     = wd;
    tick();
    read_en  = 2'b00;
    write_en = 1'b0;
  endtask

  task automatic probe(input string nm, input int a, input logic we,
                       input logic [1:0] be, input int wa,
                       input logic [15:0] wd, input logic [15:0] ea,
                       input logic [15:0] eb);
    op(2'b11, a, a, we, be, wa, wd);
    chk({nm, "_a0"}, {16'b0, data_a[15:0]},  {16'b0, ea});
    chk({nm, "_a1"}, {16'b0, data_a[31:16]}, {16'b0, ea});
    chk({nm, "_va"}, {30'b0, val_a}, 32'd3);
    tick();
    chk({nm, "_b0"}, {16'b0, data_b[15:0]},  {16'b0, eb});
    chk({nm, "_b1"}, {16'b0, data_b[31:16]}, {16'b0, eb});
    chk({nm, "_vb"}, {30'b0, val_b}, 32'd3);
  endtask

  task automatic busy_len(input string nm);
    int na, nb;
    na = 0;
    nb = 0;
    repeat (8) begin
      @(negedge clk);
      na += int'(busy_a);
      nb += int'(busy_b);
    end
    chk({nm, "_a"}, na, 5);
    chk({nm, "_b"}, nb, 5);
    tick();
  endtask

  initial begin
    read_en = 2'b00; read_addr = '0; write_en = 1'b0;
    wbe = 2'b00; waddr = '0; wdata = '0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    run = 1'b1;
    #1 rst = 1'b0;
    busy_len("init_len");

    probe("init0", 0, 1'b0, 2'b00, 0, 16'h0, 16'h0000, 16'h0000);
    for (int i = 1; i < N; i++) op(2'b11, i, i, 1'b0, 2'b00, 0, 16'h0);

    for (int i = 0; i < N; i++)
      op(2'b00, 0, 0, 1'b1, 2'b11, i, 16'haaaa + 16'(i) * 16'h1111);
    for (int i = 0; i < N; i++) op(2'b11, i, 4 - i, 1'b0, 2'b00, 0, 16'h0);
    tick();
    tick();
    probe("wr2", 2, 1'b0, 2'b00, 0, 16'h0, 16'hcccc, 16'hcccc);

    op(2'b00, 0, 0, 1'b1, 2'b11, 0, 16'h4444);
    op(2'b00, 0, 0, 1'b1, 2'b10, 0, 16'haaaa);
    probe("be10", 0, 1'b0, 2'b00, 0, 16'h0, 16'haa44, 16'haa44);
    op(2'b00, 0, 0, 1'b1, 2'b01, 0, 16'hdddd);
    probe("be01", 0, 1'b0, 2'b00, 0, 16'h0, 16'haadd, 16'haadd);
    op(2'b00, 0, 0, 1'b1, 2'b00, 0, 16'h0123);
    probe("be00", 0, 1'b0, 2'b00, 0, 16'h0, 16'haadd, 16'haadd);

    op(2'b00, 0, 0, 1'b1, 2'b11, 2, 16'h1111);
    probe("coll", 2, 1'b1, 2'b11, 2, 16'h2222, 16'h1111, 16'h2222);
    probe("after", 2, 1'b0, 2'b00, 0, 16'h0, 16'h2222, 16'h2222);

    op(2'b00, 0, 0, 1'b1, 2'b11, 7, 16'h5a5a);
    probe("oor", 7, 1'b0, 2'b00, 0, 16'h0, 16'h0000, 16'h0000);
    for (int i = 0; i < N; i++) op(2'b11, i, 4 - i, 1'b0, 2'b00, 0, 16'h0);

    repeat (400) begin
      op(2'($urandom_range(0, 3)), $urandom_range(0, 7),
         $urandom_range(0, 7), 1'($urandom_range(0, 1)),
         2'($urandom_range(0, 3)), $urandom_range(0, 7),
         16'($urandom));
    end
    tick();
    tick();

    op(2'b01, 0, 0, 1'b0, 2'b00, 0, 16'h0);
    rst = 1'b1;
    #1;
    chk("rst_va", {30'b0, val_a}, 32'd0);
    chk("rst_vb", {30'b0, val_b}, 32'd0);
    chk("rst_db", data_b, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    busy_len("reinit_len");
    probe("post_rst", 0, 1'b0, 2'b00, 0, 16'h0, 16'h0000, 16'h0000);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vc_synchronous_sram_nr1w.md
VC_SYNCHRONOUS_SRAM_NR1W -- requirements
Module: vc_SynchronousSRAM_nr1w

Interface
REQ-001 Parameter p_data_nbits, 32: width of one entry in bits.
REQ-002 Parameter p_num_entries, 256: number of entries.
REQ-003 Parameter p_num_rports, 2: number of independent read ports, 1..4.
REQ-004 Parameter p_read_latency, 1: clock edges from read request to data, 1 or 2.
REQ-005 Parameter p_write_first, 0: same-address collision mode; 0 returns old data, 1 returns new data.
REQ-006 Parameter p_init_value, 0: value written to every entry during initialisation.
REQ-007 Derived widths: c_addr_nbits = $clog2(p_num_entries); c_data_nbytes = (p_data_nbits+7)/8.
REQ-008 clk  in  1  single clock; all state updates on rising edge.
REQ-009 reset  in  1  asynchronous, active-high reset.
REQ-010 init_busy  out  1  high while initialisation sweep runs.
REQ-011 read_en  in  p_num_rports  per-port read request.
REQ-012 read_addr  in  p_num_rports*c_addr_nbits  per-port address; port i occupies slice i.
REQ-013 read_val  out  p_num_rports  per-port pulse marking valid read_data.
REQ-014 read_data  out  p_num_rports*p_data_nbits  per-port read data; port i occupies slice i.
REQ-015 write_en  in  1  write request.
REQ-016 write_byte_en  in  c_data_nbytes  per-byte write enable; bit 0 selects bits 7:0.
REQ-017 write_addr  in  c_addr_nbits  write address.
REQ-018 write_data  in  p_data_nbits  write data.

Function
REQ-019 FSM has two states, INIT and READY; init_busy = (state == INIT).
REQ-020 In INIT, each edge writes p_init_value to entry init_ctr and increments init_ctr; at init_ctr == p_num_entries-1 the next state is READY.
REQ-021 Initialisation completes in exactly p_num_entries edges after reset deasserts.
REQ-022 In INIT, read_en and write_en are ignored; read_val stays 0.
REQ-023 In READY, a write on an edge updates only the bytes whose write_byte_en bit is 1; all-zero write_byte_en leaves the entry unchanged.
REQ-024 In READY, a port with read_en high at edge N asserts read_val and presents data at edge N+p_read_latency-1 + 1, i.e. 1 edge later for latency 1 and 2 edges later for latency 2.
REQ-025 read_val is high for exactly one cycle per accepted request; back-to-back requests give back-to-back valid data at full throughput.
REQ-026 read_data holds its last value while read_val is 0.
REQ-027 Read ports are fully independent; any number of ports may read the same address in the same cycle.
REQ-028 Same-edge read and write to one address: p_write_first=0 returns pre-write contents; p_write_first=1 returns the byte-enable-merged new contents.
REQ-029 Address >= p_num_entries: the write is dropped; the read returns all zeros with read_val asserted normally.
REQ-030 Write and read in the same edge to different addresses do not interact.

Reset
REQ-031 While reset is high: state = INIT, init_ctr = 0, init_busy = 1, read_val = 0, read_data = 0, and all pipeline valid bits are 0.
REQ-032 Reset asserted mid-operation, including mid-initialisation or with reads in flight, takes effect immediately. In-flight reads are discarded, and the initialisation sweep restarts from entry 0 after deassertion.
REQ-033 Memory contents are not reset directly; they become defined only through the initialisation sweep.

Verification (p_data_nbits=16, p_num_entries=5, p_num_rports=2 unless noted)
REQ-034 Release reset -> init_busy 1 for exactly 5 cycles, then 0. Reading addresses 0..4 on both ports -> 'h0000 each.
REQ-035 Write 'haaaa, 'hbbbb, 'hcccc, 'hdddd, 'heeee to addresses 0..4, then read port0 addr 0..4 and port1 addr 4..0 on consecutive edges.
  - latency 1: data appears 1 edge later, matching the pairs.
  - latency 2: data appears 2 edges later, with read_val pulsing in lockstep.
REQ-036 Entry 0 = 'h4444. Write wben 'b10 'haaaa -> read 'haa44. Write wben 'b01 'hdddd -> read 'haadd. Write wben 'b00 'h0123 -> read 'haadd.
REQ-037 Entry 2 = 'h1111. Same edge write wben 'b11 'h2222 to addr 2 and read addr 2 on both ports:
  - p_write_first=0 -> 'h1111.
  - p_write_first=1 -> 'h2222.
  - Next read returns 'h2222 in both modes.
REQ-038 Read addr 0 issued, then reset pulsed before data returns -> read_val remains 0, read_data = 'h0000, and init_busy is 1 for 5 cycles. A read of addr 0 afterwards returns 'h0000.
REQ-039 Write to addr 7 -> no entry changes. Read addr 7 -> read_val 1 with 'h0000.
